wb_led_sequencer: RTL

WB_LED_SEQUENCER -- requirements
Module: wb_led_sequencer

---
 rtl/wb_led_sequencer.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_led_sequencer.sv
// wb_led_sequencer: Wishbone-controlled 2-bit LED pattern sequencer.
//
// Plays up to four 2-bit PATTERN entries on the LEDs, each held for PERIOD
// clocks, optionally looping, and raises a level interrupt when a
// non-looping sequence completes. Two active-low buttons start/stop it.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   i_wb_cyc/stb/we         Wishbone request qualifiers
//   i_wb_addr, i_wb_data    byte address, write data
//   o_wb_ack, o_wb_stall    single-cycle ack one clock after a decoded request; stall tied 0
//   o_wb_data               read data, valid in the ack cycle and held until the next read
//   buttons[1:0]            raw active-low buttons (0: start/stop toggle, 1: stop)
//   leds[1:0]               registered LED drive
//   seq_irq                 high while irq_pending && irq_en
//
// Register map (offset from BASE_ADDR):
//   0x00 CTRL    [0] run [1] loop [2] irq_en [3] irq_clr (write-1 pulse, reads 0)
//   0x04 PERIOD  [23:0] cycles per step, 0 is stored as 1
//   0x08 PATTERN [7:0] four 2-bit entries (entry0 at [1:0]), [9:8] length-1
//   0x0C STATUS  [1:0] index [3:2] pressed buttons [4] irq_pending [5] running (read-only)
//   0x10 MANUAL  [1:0] LED value while idle
//
// Build option: define LED_SEQ_DEBOUNCE_EN to require each synchronized
// button level to be stable for DEBOUNCE_CYCLES clocks before it is accepted.
module wb_led_sequencer #(
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0100,
    parameter logic [23:0] DEFAULT_PERIOD  = 24'd1000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    input  logic [1:0]  buttons,
    output logic [1:0]  leds,
    output logic        seq_irq
);

    localparam int unsigned DW  = 32;
    localparam int unsigned PW  = 24;
    localparam int unsigned PTW = 10;
    localparam int unsigned IW  = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            ctrl_run_q, ctrl_run_d;
    logic            ctrl_loop_q, ctrl_loop_d;
    logic            ctrl_irq_en_q, ctrl_irq_en_d;
    logic [PW-1:0]   period_q, period_d;
    logic [PW-1:0]   act_period_q, act_period_d;
    logic [PTW-1:0]  pattern_q, pattern_d;
    logic [1:0]      manual_q, manual_d;
    logic            irq_pending_q, irq_pending_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   step_cnt_q, step_cnt_d;
    logic [1:0]      leds_q, leds_d;
    logic            ack_q, ack_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            seq_irq_q, seq_irq_d;
    logic [1:0]      btn_meta_q, btn_sync_q;
    logic [1:0]      pressed_q, pressed_d;

    logic [DW-1:0]   offset;
    logic            req, hit;
    logic            wr_ctrl, wr_period, wr_pattern, wr_manual;
    logic            btn0_ev, btn1_ev;
    logic            step_end, last, start, stop;

    logic unused_wdata;
    assign unused_wdata = ^i_wb_data[31:24];

    assign o_wb_ack   = ack_q;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata_q;
    assign leds       = leds_q;
    assign seq_irq    = seq_irq_q;

    function automatic logic [1:0] entry_of(input logic [PTW-1:0] pat, input logic [IW-1:0] idx);
        case (idx)
            2'd0:    entry_of = pat[1:0];
            2'd1:    entry_of = pat[3:2];
            2'd2:    entry_of = pat[5:4];
            default: entry_of = pat[7:6];
        endcase
    endfunction

    // Pressed-state filter: the synchronized level is active-low.
`ifdef LED_SEQ_DEBOUNCE_EN
    logic [1:0][15:0] db_cnt_q, db_cnt_d;

    always_comb begin
        pressed_d = pressed_q;
        db_cnt_d  = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (~btn_sync_q[i] != pressed_q[i]) begin
                if (db_cnt_q[i] >= 16'(DEBOUNCE_CYCLES - 16'd1)) begin
                    pressed_d[i] = ~btn_sync_q[i];
                    db_cnt_d[i]  = 16'd0;
                end else begin
                    db_cnt_d[i]  = 16'(db_cnt_q[i] + 16'd1);
                end
            end else begin
                db_cnt_d[i] = 16'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) db_cnt_q <= '0;
        else          db_cnt_q <= db_cnt_d;
    end
`else
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;

    always_comb begin
        pressed_d = ~btn_sync_q;
    end
`endif

    // Bus decode, register writes, sequencer FSM and interrupt.
    always_comb begin
        state_d       = state_q;
        ctrl_run_d    = ctrl_run_q;
        ctrl_loop_d   = ctrl_loop_q;
        ctrl_irq_en_d = ctrl_irq_en_q;
        period_d      = period_q;
        act_period_d  = act_period_q;
        pattern_d     = pattern_q;
        manual_d      = manual_q;
        irq_pending_d = irq_pending_q;
        idx_d         = idx_q;
        step_cnt_d    = step_cnt_q;
        leds_d        = leds_q;
        rdata_d       = rdata_q;
        start         = 1'b0;
        stop          = 1'b0;

        offset = i_wb_addr - BASE_ADDR;
        req    = i_wb_cyc && i_wb_stb;
        hit    = (offset[31:5] == 27'd0) && (offset[4:2] <= 3'd4) && (offset[1:0] == 2'b00);
        ack_d  = req && hit;

        wr_ctrl    = req && hit && i_wb_we && (offset[4:2] == 3'd0);
        wr_period  = req && hit && i_wb_we && (offset[4:2] == 3'd1);
        wr_pattern = req && hit && i_wb_we && (offset[4:2] == 3'd2);
        wr_manual  = req && hit && i_wb_we && (offset[4:2] == 3'd4);

        btn0_ev = pressed_d[0] && !pressed_q[0];
        btn1_ev = pressed_d[1] && !pressed_q[1];

        // Undecoded reads clear the data bus so stale data is never re-presented.
        if (req && !i_wb_we) begin
            if (hit) begin
                case (offset[4:2])
                    3'd0:    rdata_d = {29'd0, ctrl_irq_en_q, ctrl_loop_q, ctrl_run_q};
                    3'd1:    rdata_d = {8'd0, period_q};
                    3'd2:    rdata_d = {22'd0, pattern_q};
                    3'd3:    rdata_d = {26'd0, state_q == S_RUN, irq_pending_q, pressed_q, idx_q};
                    default: rdata_d = {30'd0, manual_q};
                endcase
            end else begin
                rdata_d = '0;
            end
        end

        if (wr_ctrl) begin
            ctrl_loop_d   = i_wb_data[1];
            ctrl_irq_en_d = i_wb_data[2];
        end
        if (wr_period)  period_d  = (i_wb_data[23:0] == 24'd0) ? 24'd1 : i_wb_data[23:0];
        if (wr_pattern) pattern_d = i_wb_data[9:0];
        if (wr_manual)  manual_d  = i_wb_data[1:0];

        step_end = (step_cnt_q == PW'(act_period_q - 24'd1));
        last     = (idx_q == pattern_d[9:8]);

        // Priority: button1 stop > CPU CTRL write > button0 toggle > step terminal.
        case (state_q)
            S_IDLE: begin
                leds_d = manual_d;
                if (btn1_ev) begin
                    ctrl_run_d = 1'b0;
                end else if (wr_ctrl) begin
                    start = i_wb_data[0];
                end else if (btn0_ev) begin
                    start = 1'b1;
                end
                if (start) begin
                    state_d      = S_RUN;
                    ctrl_run_d   = 1'b1;
                    idx_d        = '0;
                    step_cnt_d   = '0;
                    act_period_d = period_d;
                    leds_d       = entry_of(pattern_d, 2'd0);
                end
            end
            default: begin
                stop = btn1_ev || (wr_ctrl && !i_wb_data[0]) || (!wr_ctrl && btn0_ev);
                if (stop) begin
                    state_d    = S_IDLE;
                    ctrl_run_d = 1'b0;
                    idx_d      = '0;
                    step_cnt_d = '0;
                    leds_d     = manual_d;
                end else if (step_end) begin
                    step_cnt_d   = '0;
                    act_period_d = period_d;
                    // A same-cycle CTRL write with run=1 outranks completion, so the sequence wraps.
                    if (last && !ctrl_loop_d && !wr_ctrl) begin
                        state_d       = S_IDLE;
                        ctrl_run_d    = 1'b0;
                        irq_pending_d = 1'b1;
                        idx_d         = '0;
                        leds_d        = manual_d;
                    end else begin
                        idx_d  = last ? 2'd0 : IW'(idx_q + 2'd1);
                        leds_d = entry_of(pattern_d, idx_d);
                    end
                end else begin
                    step_cnt_d = PW'(step_cnt_q + 24'd1);
                end
            end
        endcase

        // Clear outranks a same-cycle set.
        if (wr_ctrl && i_wb_data[3]) irq_pending_d = 1'b0;
        seq_irq_d = irq_pending_d && ctrl_irq_en_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            ctrl_run_q    <= 1'b0;
            ctrl_loop_q   <= 1'b0;
            ctrl_irq_en_q <= 1'b0;
            period_q      <= DEFAULT_PERIOD;
            act_period_q  <= DEFAULT_PERIOD;
            pattern_q     <= '0;
            manual_q      <= '0;
            irq_pending_q <= 1'b0;
            idx_q         <= '0;
            step_cnt_q    <= '0;
            leds_q        <= '0;
            ack_q         <= 1'b0;
            rdata_q       <= '0;
            seq_irq_q     <= 1'b0;
            btn_meta_q    <= 2'b11;
            btn_sync_q    <= 2'b11;
            pressed_q     <= 2'b00;
        end else begin
            state_q       <= state_d;
            ctrl_run_q    <= ctrl_run_d;
            ctrl_loop_q   <= ctrl_loop_d;
            ctrl_irq_en_q <= ctrl_irq_en_d;
            period_q      <= period_d;
            act_period_q  <= act_period_d;
            pattern_q     <= pattern_d;
            manual_q      <= manual_d;
            irq_pending_q <= irq_pending_d;
            idx_q         <= idx_d;
            step_cnt_q    <= step_cnt_d;
            leds_q        <= leds_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            seq_irq_q     <= seq_irq_d;
            btn_meta_q    <= buttons;
            btn_sync_q    <= btn_meta_q;
            pressed_q     <= pressed_d;
        end
    end

endmodule
